// File: rtl/sti_pkg.sv
// Shared types for the STI parallel-input feeder.
//   state_t      : feeder FSM states
//   len_t        : frame length codes (8/16/24/32 bits)
//   desc_t       : packed FIFO entry {last,low,msb,fill,length,data}
//   bits_for_len : serial bit count expected for a length code
package sti_pkg;

  localparam int unsigned DESC_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_TX,
    ST_GAP,
    ST_END_LD,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    LEN_8  = 2'd0,
    LEN_16 = 2'd1,
    LEN_24 = 2'd2,
    LEN_32 = 2'd3
  } len_t;

  typedef struct packed {
    logic        last;
    logic        low;
    logic        msb;
    logic        fill;
    len_t        length;
    logic [15:0] data;
  } desc_t;

  // 8 * (length + 1)
  function automatic logic [5:0] bits_for_len(input len_t length);
    return {1'b0, length, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_desc_fifo.sv
// Synchronous descriptor FIFO with occupancy count.
// Ports:
//   clk, reset (async, active-low)
//   push/push_data : write side; a push while full is dropped, even if a pop
//                    happens in the same cycle
//   pop/pop_data   : read side; pop_data shows the head combinationally
//   full, empty, count : status, count is log2(DEPTH)+1 bits
module sti_desc_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sti_pi_feeder.sv
// Feeds buffered host descriptors to the serial transmitter's parallel-input
// bus one at a time, pacing on the transmitter's so_valid bursts, and issues
// a terminating pi_end load after the descriptor marked last.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_data, cmd_length, cmd_fill, cmd_msb, cmd_low,
//   cmd_last           : host descriptor input
//   load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end
//                      : transmitter parallel-input bus, load is a 1-cycle strobe
//   so_valid           : transmitter serial-valid (monitored)
//   busy, done, len_err: status; done and len_err are sticky
// Optional build macro STI_PI_FEEDER_TIMEOUT_EN adds TIMEOUT_CYC, the
// timeout_err output and a watchdog that abandons a frame whose so_valid
// burst never starts.
module sti_pi_feeder
  import sti_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP_CYC = 1
`ifdef STI_PI_FEEDER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [1:0]  cmd_length,
  input  logic        cmd_fill,
  input  logic        cmd_msb,
  input  logic        cmd_low,
  input  logic        cmd_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  output logic        busy,
  output logic        done,
  output logic        len_err
`ifdef STI_PI_FEEDER_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t           state;
  state_t           state_n;
  desc_t            in_desc;
  desc_t            head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic [5:0]       bit_cnt;
  logic [5:0]       exp_bits;
  logic [3:0]       gap_cnt;
  logic             tx_prev;
  logic             tx_seen;
  logic             last_pend;
  logic             tx_fall;
  logic             timeout_hit;
  logic             frame_end;

  assign in_desc = '{last: cmd_last, low: cmd_low, msb: cmd_msb, fill: cmd_fill,
                     length: len_t'(cmd_length), data: cmd_data};

  sti_desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (in_desc),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == ST_LOAD);
  assign load      = (state == ST_LOAD) || (state == ST_END_LD);
  assign done      = (state == ST_DONE);
  assign busy      = ((state != ST_IDLE) && (state != ST_DONE)) || (fifo_count != '0);

  // tx_prev is only tracked inside WAIT_TX, so so_valid seen in other states
  // never produces a falling edge here.
  assign tx_fall   = (state == ST_WAIT_TX) && tx_prev && !so_valid;
  assign frame_end = tx_fall || timeout_hit;

`ifdef STI_PI_FEEDER_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // wd_cnt counts cycles since the load strobe (load cycle = 1).
  assign timeout_hit = (state == ST_WAIT_TX) && !tx_seen && !so_valid &&
                       (wd_cnt >= 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_LOAD) begin
        wd_cnt <= 8'd1;
      end else if ((state == ST_WAIT_TX) && !tx_seen && (wd_cnt != '1)) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (!fifo_empty) state_n = ST_LOAD;
      ST_LOAD:    state_n = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (frame_end) begin
          if (last_pend)         state_n = ST_END_LD;
          else if (GAP_CYC == 0) state_n = ST_IDLE;
          else                   state_n = ST_GAP;
        end
      end
      ST_GAP:     if (gap_cnt == 4'(GAP_CYC - 1)) state_n = ST_IDLE;
      ST_END_LD:  state_n = ST_DONE;
      ST_DONE:    state_n = ST_DONE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pi_data   <= '0;
      pi_length <= '0;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
      pi_end    <= 1'b0;
      last_pend <= 1'b0;
      bit_cnt   <= '0;
      exp_bits  <= '0;
      gap_cnt   <= '0;
      tx_prev   <= 1'b0;
      tx_seen   <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      // The head is captured on entry to LOAD so pi_* are already valid while
      // the load strobe is high; the pop itself happens in the LOAD cycle.
      if ((state == ST_IDLE) && (state_n == ST_LOAD)) begin
        pi_data   <= head.data;
        pi_length <= head.length;
        pi_fill   <= head.fill;
        pi_msb    <= head.msb;
        pi_low    <= head.low;
        pi_end    <= 1'b0;
        last_pend <= head.last;
        exp_bits  <= bits_for_len(head.length);
      end
      if ((state != ST_END_LD) && (state_n == ST_END_LD)) begin
        pi_data <= '0;
        pi_end  <= 1'b1;
      end
      case (state)
        ST_LOAD: begin
          bit_cnt <= '0;
          gap_cnt <= '0;
          tx_prev <= 1'b0;
          tx_seen <= 1'b0;
        end
        ST_WAIT_TX: begin
          tx_prev <= so_valid;
          if (so_valid) begin
            bit_cnt <= bit_cnt + 6'd1;
            tx_seen <= 1'b1;
          end
          if (tx_fall && (bit_cnt != exp_bits)) len_err <= 1'b1;
        end
        ST_GAP:  gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sti_pi_feeder.sv
module tb_sti_pi_feeder;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned GAP_CYC = 1;
`ifdef STI_PI_FEEDER_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [1:0]  cmd_length = '0;
  logic        cmd_fill = 1'b0;
  logic        cmd_msb = 1'b0;
  logic        cmd_low = 1'b0;
  logic        cmd_last = 1'b0;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill;
  logic        pi_msb;
  logic        pi_low;
  logic        pi_end;
  logic        so_valid = 1'b0;
  logic        busy;
  logic        done;
  logic        len_err;
`ifdef STI_PI_FEEDER_TIMEOUT_EN
  logic        timeout_err;
`endif

  sti_pi_feeder #(
    .DEPTH   (DEPTH),
    .GAP_CYC (GAP_CYC)
`ifdef STI_PI_FEEDER_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_length (cmd_length),
    .cmd_fill   (cmd_fill),
    .cmd_msb    (cmd_msb),
    .cmd_low    (cmd_low),
    .cmd_last   (cmd_last),
    .load       (load),
    .pi_data    (pi_data),
    .pi_length  (pi_length),
    .pi_fill    (pi_fill),
    .pi_msb     (pi_msb),
    .pi_low     (pi_low),
    .pi_end     (pi_end),
    .so_valid   (so_valid),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err)
`ifdef STI_PI_FEEDER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic        last;
  } dsc_t;

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic        pend;
  } ld_t;

  // Reference model: accepted descriptors in issue order, observed loads,
  // and whether any served burst so far had the wrong length.
  dsc_t exp_q[$];
  ld_t  loads[$];
  bit   exp_len_err = 1'b0;

  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    if (reset && load) begin
      loads.push_back('{cyc: cyc, data: pi_data, len: pi_length, fill: pi_fill,
                        msb: pi_msb, low: pi_low, pend: pi_end});
    end
  end

  function automatic int unsigned frame_bits(input logic [1:0] len);
    return (32'(len) + 1) * 8;
  endfunction

  function automatic dsc_t rand_desc(input logic last);
    dsc_t d;
    d.data = 16'($urandom);
    d.len  = 2'($urandom_range(0, 3));
    d.fill = 1'($urandom);
    d.msb  = 1'($urandom);
    d.low  = 1'($urandom);
    d.last = last;
    return d;
  endfunction

  function automatic bit rec_ok(input ld_t r, input dsc_t e);
    return (r.data === e.data) && (r.len === e.len) && (r.fill === e.fill) &&
           (r.msb === e.msb) && (r.low === e.low) && (r.pend === 1'b0);
  endfunction

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Starts and ends at posedge+1 so consecutive calls push back-to-back.
  task automatic push_desc(input dsc_t d, output int unsigned pc, output bit ok);
    cmd_valid  = 1'b1;
    cmd_data   = d.data;
    cmd_length = d.len;
    cmd_fill   = d.fill;
    cmd_msb    = d.msb;
    cmd_low    = d.low;
    cmd_last   = d.last;
    ok = 1'b0;
    pc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        pc = cyc;
        break;
      end
    end
    to_pos();
    cmd_valid = 1'b0;
    if (ok) exp_q.push_back(d);
  endtask

  task automatic wait_load(output ld_t r, output bit ok);
    ok = 1'b0;
    r  = '{default: 0};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (loads.size() != 0) begin
        r  = loads.pop_front();
        ok = 1'b1;
        break;
      end
    end
    to_pos();
  endtask

  task automatic drive_so(input int unsigned n);
    so_valid = 1'b1;
    repeat (n) to_pos();
    so_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({load, cmd_ready, busy, done, len_err, pi_end} !== 6'b010000) begin
      bad++;
      $display("FAIL reset_ctl: got %b want %b", {load, cmd_ready, busy, done, len_err, pi_end}, 6'b010000);
    end
    total++;
    if ({pi_data, pi_length, pi_fill, pi_msb, pi_low} !== 21'h0) begin
      bad++;
      $display("FAIL reset_pi: got %h want 0", {pi_data, pi_length, pi_fill, pi_msb, pi_low});
    end
    to_pos();
    to_pos();
    reset = 1'b1;
    to_neg();
    total++;
    if ({load, cmd_ready, busy, done} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", {load, cmd_ready, busy, done}, 4'b0100);
    end
    to_pos();
  endtask

  task automatic test_single();
    dsc_t d, e;
    ld_t r;
    int unsigned pc;
    bit ok;
    d = '{data: 16'hA5C3, len: 2'd1, fill: 1'b0, msb: 1'b1, low: 1'b0, last: 1'b0};
    push_desc(d, pc, ok);
    wait_load(r, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_load: got none want load"); return; end
    e = exp_q.pop_front();
    total++;
    if (r.cyc !== pc + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", r.cyc, pc + 2); end
    total++;
    if (!rec_ok(r, e)) begin bad++; $display("FAIL single_fields: got %h/%0d want %h/%0d", r.data, r.len, e.data, e.len); end
    drive_so(frame_bits(e.len));
    repeat (4) to_pos();
    to_neg();
    total++;
    if ({load, len_err, busy, done} !== {1'b0, exp_len_err, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL single_after: got %b want %b", {load, len_err, busy, done}, {1'b0, exp_len_err, 2'b00});
    end
    total++;
    if (pi_data !== e.data || loads.size() != 0) begin
      bad++;
      $display("FAIL single_hold: got %h extra=%0d want %h extra=0", pi_data, loads.size(), e.data);
    end
    to_pos();
  endtask

  task automatic test_back_to_back();
    dsc_t d, e;
    ld_t r;
    int unsigned pc, p5, f;
    bit ok;
    d = rand_desc(1'b0);
    d.len = 2'd0;
    push_desc(d, pc, ok);
    wait_load(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || !rec_ok(r, e)) begin bad++; $display("FAIL b2b_first: got %h want %h", r.data, e.data); end
    // Transmitter stalled: four descriptors fill the FIFO.
    for (int i = 0; i < 4; i++) begin
      push_desc(rand_desc(1'b0), pc, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_push%0d: got refused want accepted", i); end
    end
    to_neg();
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got cmd_ready=%b want 0", cmd_ready); end
    to_pos();
    drive_so(frame_bits(e.len));
    push_desc(rand_desc(1'b0), p5, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_push5: got refused want accepted"); end
    f = 0;
    for (int k = 0; k < 5; k++) begin
      wait_load(r, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || !rec_ok(r, e)) begin
        bad++;
        $display("FAIL b2b_order%0d: got %h/%0d want %h/%0d", k, r.data, r.len, e.data, e.len);
      end
      if (k == 0) begin
        total++;
        if (p5 !== r.cyc + 1) begin bad++; $display("FAIL b2b_push5_cycle: got %0d want %0d", p5, r.cyc + 1); end
      end else begin
        total++;
        if (r.cyc !== f + 2 + GAP_CYC) begin bad++; $display("FAIL b2b_spacing%0d: got %0d want %0d", k, r.cyc, f + 2 + GAP_CYC); end
      end
      drive_so(frame_bits(e.len));
      f = cyc;
    end
    repeat (4) to_pos();
    to_neg();
    total++;
    if ({busy, len_err} !== {1'b0, exp_len_err}) begin
      bad++;
      $display("FAIL b2b_end: got %b want %b", {busy, len_err}, {1'b0, exp_len_err});
    end
    to_pos();
  endtask

  task automatic test_len_err();
    dsc_t a, e;
    ld_t r;
    int unsigned pc, f;
    bit ok;
    a = rand_desc(1'b0);
    a.len = 2'd2;
    push_desc(a, pc, ok);
    push_desc(rand_desc(1'b0), pc, ok);
    wait_load(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || !rec_ok(r, e)) begin bad++; $display("FAIL lenerr_load: got %h want %h", r.data, e.data); end
    drive_so(23);
    if (23 != frame_bits(e.len)) exp_len_err = 1'b1;
    f = cyc;
    wait_load(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || !rec_ok(r, e) || r.cyc !== f + 2 + GAP_CYC) begin
      bad++;
      $display("FAIL lenerr_next: got %h@%0d want %h@%0d", r.data, r.cyc, e.data, f + 2 + GAP_CYC);
    end
    total++;
    if (len_err !== exp_len_err) begin bad++; $display("FAIL lenerr_flag: got %b want %b", len_err, exp_len_err); end
    drive_so(frame_bits(e.len));
    repeat (4) to_pos();
    to_neg();
    total++;
    if ({len_err, busy} !== {exp_len_err, 1'b0}) begin
      bad++;
      $display("FAIL lenerr_sticky: got %b want %b", {len_err, busy}, {exp_len_err, 1'b0});
    end
    to_pos();
  endtask

  task automatic test_reset_mid_frame();
    dsc_t e, c;
    ld_t r;
    int unsigned pc;
    bit ok;
    push_desc(rand_desc(1'b0), pc, ok);
    push_desc(rand_desc(1'b0), pc, ok);
    wait_load(r, ok);
    so_valid = 1'b1;
    repeat (5) to_pos();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({load, cmd_ready, busy, done, len_err, pi_end} !== 6'b010000) begin
      bad++;
      $display("FAIL midreset_ctl: got %b want %b", {load, cmd_ready, busy, done, len_err, pi_end}, 6'b010000);
    end
    total++;
    if (pi_data !== 16'h0) begin bad++; $display("FAIL midreset_pi: got %h want 0", pi_data); end
    so_valid = 1'b0;
    exp_q.delete();
    loads.delete();
    exp_len_err = 1'b0;
    to_pos();
    reset = 1'b1;
    // Spurious so_valid while idle must not raise len_err.
    so_valid = 1'b1;
    repeat (3) to_pos();
    so_valid = 1'b0;
    to_pos();
    c = rand_desc(1'b0);
    push_desc(c, pc, ok);
    wait_load(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || !rec_ok(r, e) || r.cyc !== pc + 2) begin
      bad++;
      $display("FAIL midreset_fresh: got %h@%0d want %h@%0d", r.data, r.cyc, e.data, pc + 2);
    end
    drive_so(frame_bits(e.len));
    repeat (4) to_pos();
    to_neg();
    total++;
    if ({len_err, busy} !== {exp_len_err, 1'b0}) begin
      bad++;
      $display("FAIL midreset_after: got %b want %b", {len_err, busy}, {exp_len_err, 1'b0});
    end
    to_pos();
  endtask

`ifdef STI_PI_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    dsc_t e;
    ld_t r;
    int unsigned pc, l;
    bit ok;
    push_desc(rand_desc(1'b0), pc, ok);
    push_desc(rand_desc(1'b0), pc, ok);
    wait_load(r, ok);
    e = exp_q.pop_front();
    l = r.cyc;
    while (cyc < l + TIMEOUT_CYC - 1) to_pos();
    to_neg();
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
    to_pos();
    to_neg();
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_flag: got %b want 1", timeout_err); end
    to_pos();
    wait_load(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || !rec_ok(r, e) || r.cyc !== l + TIMEOUT_CYC + 1 + GAP_CYC) begin
      bad++;
      $display("FAIL timeout_next: got %h@%0d want %h@%0d", r.data, r.cyc, e.data, l + TIMEOUT_CYC + 1 + GAP_CYC);
    end
    drive_so(frame_bits(e.len));
    repeat (4) to_pos();
    to_neg();
    total++;
    if ({timeout_err, len_err, busy} !== {1'b1, exp_len_err, 1'b0}) begin
      bad++;
      $display("FAIL timeout_after: got %b want %b", {timeout_err, len_err, busy}, {1'b1, exp_len_err, 1'b0});
    end
    to_pos();
  endtask
`endif

  task automatic test_end();
    dsc_t e;
    ld_t r;
    int unsigned pc, f;
    bit ok;
    push_desc(rand_desc(1'b1), pc, ok);
    wait_load(r, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || !rec_ok(r, e)) begin bad++; $display("FAIL end_desc: got %h want %h", r.data, e.data); end
    drive_so(frame_bits(e.len));
    f = cyc;
    wait_load(r, ok);
    total++;
    if (!ok || r.pend !== 1'b1 || r.data !== 16'h0 || r.cyc !== f + 1) begin
      bad++;
      $display("FAIL end_load: got end=%b data=%h@%0d want end=1 data=0@%0d", r.pend, r.data, r.cyc, f + 1);
    end
    to_neg();
    total++;
    if ({done, busy, load, pi_end} !== 4'b1001) begin
      bad++;
      $display("FAIL end_done: got %b want %b", {done, busy, load, pi_end}, 4'b1001);
    end
    to_pos();
    push_desc(rand_desc(1'b0), pc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL end_push: got refused want accepted"); end
    repeat (10) to_pos();
    to_neg();
    total++;
    if ({done, busy, pi_end} !== 3'b111 || loads.size() != 0) begin
      bad++;
      $display("FAIL end_hold: got %b loads=%0d want 111 loads=0", {done, busy, pi_end}, loads.size());
    end
    to_pos();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_len_err();
    test_reset_mid_frame();
`ifdef STI_PI_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    test_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sti_pi_feeder.md
Name: sti_pi_feeder

Overview:
- Upstream stage of the serial transmitter/DAC block.
- Buffers 16-bit data descriptors from a host command interface in a small FIFO and presents them one at a time on the transmitter's parallel-input bus (load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end).
- Paces descriptors by counting the transmitter's so_valid pulses, so a new descriptor is never loaded mid-frame.
- After the last descriptor, issues the terminating pi_end load.

Parameters:
- DEPTH, 4, descriptor FIFO entries (power of two, ≥2)
- GAP_CYC, 1, idle cycles inserted between end of a frame and the next load (0..15)
- TIMEOUT_CYC, 64, cycles to wait for so_valid after load (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  host descriptor valid
- cmd_ready  out  1  FIFO can accept a descriptor
- cmd_data  in  16  payload
- cmd_length  in  2  0=8b, 1=16b, 2=24b, 3=32b frame
- cmd_fill  in  1  fill flag
- cmd_msb  in  1  MSB-first flag
- cmd_low  in  1  low-byte select for 8b frames
- cmd_last  in  1  final descriptor of the stream
- load  out  1  one-cycle load strobe to the transmitter
- pi_data  out  16  payload
- pi_length  out  2  frame length code
- pi_fill  out  1  fill flag
- pi_msb  out  1  MSB-first flag
- pi_low  out  1  low-byte select
- pi_end  out  1  end-of-stream marker
- so_valid  in  1  transmitter serial-valid, monitored only
- busy  out  1  frame in flight or FIFO non-empty
- done  out  1  sticky after the pi_end load completes
- len_err  out  1  sticky: so_valid burst length ≠ expected bits

Behaviour:
- Reset (reset low, async): FIFO empty; state IDLE. All outputs 0 except cmd_ready=1.
- FIFO: 22-bit entries {last,low,msb,fill,length,data}. cmd_ready = !full. Push when cmd_valid&&cmd_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Pop in LOAD state only. Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- States:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD: pop head into output registers; load=1 for exactly this cycle; clear bit counter; capture expected bits = 8*(length+1). If popped entry has last=1, set last_pend. Next state WAIT_TX.
  - WAIT_TX: while so_valid, increment 6-bit bit counter. On so_valid falling edge (prev=1, now=0), compare counter with expected bits; on mismatch set len_err. Then go to GAP, or to END_LD if last_pend.
  - GAP: count GAP_CYC cycles (skip directly if 0), then go to IDLE.
  - END_LD: pi_end=1, pi_data=0, load=1 for one cycle; go to DONE.
  - DONE: hold; done=1. New pushes are still accepted into the FIFO but are not issued until reset.
- pi_* outputs are registered and held stable from the LOAD cycle until the next LOAD. pi_end stays 1 in DONE.
- busy = (state≠IDLE && state≠DONE) || !empty.
- so_valid high in IDLE/GAP (spurious): ignored, no error.
- Latency: descriptor pushed into an empty FIFO while IDLE → load asserted 2 cycles after the push cycle.

Optional Feature:
- Macro STI_PI_FEEDER_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (sticky) and an 8-bit watchdog.
  - The watchdog counts in WAIT_TX while no so_valid has yet been seen. On reaching TIMEOUT_CYC: set timeout_err, abandon the frame, and take the normal WAIT_TX exit (GAP or END_LD).
- Undefined: no port, no watchdog; WAIT_TX waits indefinitely.

Decomposition:
- Shared package sti_pkg: state enum, length codes, function bits_for_len(length)→6-bit, descriptor width constant (22).
- One sub-module, sti_desc_fifo: parameterised synchronous FIFO with full/empty/count.
- FSM, counters and output registers stay in sti_pi_feeder.

Test Plan:
- Single descriptor (data=16'hA5C3, length=1, msb=1), with a bench model driving so_valid for 16 cycles → load pulses once, pi_data=A5C3 held, len_err=0; then the terminating load with pi_end=1 only if last=1.
- DEPTH=4: push 5 descriptors back-to-back while the transmitter is stalled → cmd_ready falls after 4 pushes; 5th accepted after the first pop; loads arrive in push order.
- so_valid burst of 23 cycles for length=2 (expects 24) → len_err=1 sticky; next descriptor still loaded after GAP_CYC.
- Descriptor with last=1 → after its burst plus one cycle, load=1 with pi_end=1, pi_data=0; done=1 next cycle; busy=0.
- Reset asserted low mid-WAIT_TX → outputs immediately 0, FIFO empty, cmd_ready=1; after release, a fresh descriptor loads with 2-cycle latency.
- With STI_PI_FEEDER_TIMEOUT_EN, TIMEOUT_CYC=10, so_valid never asserts → timeout_err=1 at cycle 10 after load; feeder advances to the next descriptor.
